instruction_fetch_mem: RTL and testbench
========================================

// Module: instruction_fetch_mem
// PURPOSE
//  Parametrised, loadable instruction memory for the MIPS core fetch stage.
//  Program words are written through a load port while the block is in LOAD mode.
//  After load_done it serves fetch requests with 1-cycle registered latency,
//  stall hold, PC tagging and a sticky fault on out-of-range or misaligned PC.
//  Sits between the PC register and the decode stage.
// PARAMETERS
//  DATA_W    32      instruction width in bits
//  DEPTH     1024    number of instruction words
//  ADDR_W    10      word-index width, >= clog2(DEPTH)
//  PC_W      12      fetch PC width in bits
//  BYTE_ADDR 1       1: PC is a byte address, index = pc>>2, pc[1:0]!=0 is a fault; 0: PC is a word index
//  NOP_WORD  32'h0   value driven on instr at reset, in fault, and before any fetch
// PORTS
//  clk          in   1       rising-edge clock
//  rst          in   1       synchronous reset, active-high
//  load_we      in   1       write strobe for load_data into mem[load_addr] (LOAD state only)
//  load_addr    in   ADDR_W  word index for the load write
//  load_data    in   DATA_W  program word to write
//  load_done    in   1       end of program load; moves LOAD->RUN
//  fetch_req    in   1       fetch request for fetch_pc
//  fetch_pc     in   PC_W    PC of the requested instruction
//  stall        in   1       downstream stall: hold all outputs, drop the request
//  instr        out  DATA_W  fetched instruction (registered)
//  instr_valid  out  1       instr/instr_pc are new this cycle
//  instr_pc     out  PC_W    PC that produced instr
//  ready        out  1       1 in RUN state (fetches accepted)
//  fault        out  1       sticky: bad PC seen; cleared only by rst
// BEHAVIOUR
//  Reset (sync, rst=1 at edge)
//   - state=LOAD, instr=NOP_WORD, instr_valid=0, instr_pc=0, ready=0, fault=0.
//   - Memory contents are NOT cleared.
//  States LOAD -> RUN -> FAULT; FAULT exits only via rst.
//  LOAD
//   - load_we=1 and load_addr<DEPTH: mem[load_addr]<=load_data at the edge.
//   - load_addr>=DEPTH: write dropped, no fault.
//   - fetch_req and stall are ignored; instr_valid=0.
//   - load_done=1: next state RUN. A load_we in the same cycle is still performed.
//  RUN
//   - ready=1; load_we and load_done are ignored.
//   - stall=1: instr, instr_valid, instr_pc hold their values.
//     fetch_req is dropped, not queued, and not range-checked (stall wins over fault).
//   - stall=0, fetch_req=0: instr_valid<=0; instr and instr_pc hold.
//   - stall=0, fetch_req=1, PC good: next edge instr<=mem[idx], instr_pc<=fetch_pc, instr_valid<=1.
//     Latency is exactly 1 cycle; a back-to-back request every cycle gives full throughput.
//   - idx = BYTE_ADDR ? fetch_pc[PC_W-1:2] : fetch_pc.
//   - PC is bad if idx>=DEPTH, or if BYTE_ADDR=1 and fetch_pc[1:0]!=0.
//   - Bad PC, stall=0, fetch_req=1: next state FAULT, fault<=1, instr<=NOP_WORD,
//     instr_valid<=0, instr_pc<=fetch_pc (the offending PC).
//  FAULT
//   - ready=0; all inputs except rst ignored; outputs hold.
//  rst mid-operation (any state): return to LOAD next edge, outputs to reset values.
//   - Memory is kept, so asserting load_done alone re-enters RUN with the old program.
//  Read-during-write cannot occur: writes happen only in LOAD, reads only in RUN.
// TESTING
//  T1 reset: rst=1 one cycle -> instr=0, instr_valid=0, ready=0, fault=0; mem[0] unchanged from pre-reset value.
//  T2 load/fetch (BYTE_ADDR=1): write mem[0..3]=32'h20010007,32'h20020009,32'h00221820,32'hAC030000; load_done;
//     fetch_pc=0,4,8,12 on consecutive cycles -> one cycle later each word appears in order, instr_valid=1 each cycle, instr_pc=0,4,8,12.
//  T3 stall: fetch_pc=4 accepted, then stall=1 for 3 cycles with fetch_req=1, fetch_pc=8
//     -> instr=32'h20020009, instr_pc=4, instr_valid held for 3 cycles; word at PC 8 appears only after re-request with stall=0.
//  T4 faults: fetch_pc=6 -> fault=1, instr=0, instr_pc=6, ready=0; rst then load_done then fetch_pc=4096 (idx 1024 = DEPTH) -> fault=1.
//     stall=1 with fetch_pc=6 -> no fault.
//  T5 mode guards: load_we in RUN to addr 0 -> mem[0] unchanged; fetch_req in LOAD -> instr_valid stays 0;
//     load_addr=1024 write -> dropped, no fault.

Source files
------------

// File: rtl/instruction_fetch_mem.sv
// instruction_fetch_mem
//   Loadable instruction memory for the fetch stage. While in LOAD the
//   program is written through the load port. After load_done the block
//   moves to RUN and answers fetch requests with one cycle of registered
//   latency. A misaligned or out-of-range PC moves it to FAULT, which only
//   rst can leave.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   synchronous reset, active-high
//   load_we      in   write strobe (LOAD only)
//   load_addr    in   [ADDR_W] word index of the load write
//   load_data    in   [DATA_W] program word
//   load_done    in   end of load, LOAD -> RUN
//   fetch_req    in   fetch request for fetch_pc
//   fetch_pc     in   [PC_W] PC of the requested instruction
//   stall        in   hold outputs, drop the request
//   instr        out  [DATA_W] fetched instruction (registered)
//   instr_valid  out  instr/instr_pc are new this cycle
//   instr_pc     out  [PC_W] PC that produced instr
//   ready        out  1 while in RUN
//   fault        out  sticky bad-PC flag, cleared by rst
module instruction_fetch_mem #(
  parameter int          DATA_W    = 32,
  parameter int          DEPTH     = 1024,
  parameter int          ADDR_W    = 10,
  parameter int          PC_W      = 12,
  parameter int          BYTE_ADDR = 1,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_done,
  input  logic              fetch_req,
  input  logic [PC_W-1:0]   fetch_pc,
  input  logic              stall,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic [PC_W-1:0]   instr_pc,
  output logic              ready,
  output logic              fault
);

  // Wide enough to hold both the word index and DEPTH without truncation.
  localparam int IW = (PC_W > 32) ? PC_W : 32;
  localparam int LW = (ADDR_W > 32) ? ADDR_W : 32;

  typedef enum logic [1:0] {S_LOAD, S_RUN, S_FAULT} state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [IW-1:0]     w_idx;
  logic              w_bad_pc;
  logic              w_load_ok;
  logic              w_take;

  logic [DATA_W-1:0] r_instr_p1;
  logic              r_vld_p1;
  logic [PC_W-1:0]   r_pc_p1;
  logic              r_fault;

  assign w_idx = (BYTE_ADDR != 0) ? IW'(fetch_pc >> 2) : IW'(fetch_pc);

  always_comb begin
    w_bad_pc = (w_idx >= IW'(DEPTH));
    if ((BYTE_ADDR != 0) && (fetch_pc[1:0] != 2'b00)) begin
      w_bad_pc = 1'b1;
    end
  end

  assign w_load_ok = (r_state == S_LOAD) && load_we && (LW'(load_addr) < LW'(DEPTH));
  // A fetch is only looked at in RUN without stall; stall also suppresses the range check.
  assign w_take    = (r_state == S_RUN) && !stall && fetch_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_LOAD:  if (load_done) w_state_nxt = S_RUN;
      S_RUN:   if (w_take && w_bad_pc) w_state_nxt = S_FAULT;
      S_FAULT: w_state_nxt = S_FAULT;
      default: w_state_nxt = S_LOAD;
    endcase
  end

  always_comb begin
    ready = (r_state == S_RUN);
  end

  // Program storage: not reset, so a reload-free restart reuses the old program.
  always_ff @(posedge clk) begin
    if (w_load_ok) begin
      r_mem[load_addr] <= load_data;
    end
  end

  // Stage p0 -> p1: registered fetch result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_instr_p1 <= NOP_WORD;
      r_vld_p1   <= 1'b0;
      r_pc_p1    <= '0;
      r_fault    <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: r_vld_p1 <= 1'b0;
        S_RUN: begin
          if (!stall) begin
            if (fetch_req) begin
              r_pc_p1 <= fetch_pc;
              if (w_bad_pc) begin
                r_instr_p1 <= NOP_WORD;
                r_vld_p1   <= 1'b0;
                r_fault    <= 1'b1;
              end else begin
                r_instr_p1 <= r_mem[w_idx[ADDR_W-1:0]];
                r_vld_p1   <= 1'b1;
              end
            end else begin
              r_vld_p1 <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign instr       = r_instr_p1;
  assign instr_valid = r_vld_p1;
  assign instr_pc    = r_pc_p1;
  assign fault       = r_fault;

endmodule

// File: tb/tb_instruction_fetch_mem.sv
module tb_instruction_fetch_mem;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 1024;
  localparam int ADDR_W = 11;
  localparam int PC_W   = 13;

  logic              clk = 1'b0;
  logic              rst;
  logic              load_we;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
  logic              load_done;
  logic              fetch_req;
  logic [PC_W-1:0]   fetch_pc;
  logic              stall;
  logic [DATA_W-1:0] instr;
  logic              instr_valid;
  logic [PC_W-1:0]   instr_pc;
  logic              ready;
  logic              fault;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  instruction_fetch_mem #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .PC_W(PC_W),
    .BYTE_ADDR(1), .NOP_WORD(32'h0)
  ) dut (
    .clk(clk), .rst(rst),
    .load_we(load_we), .load_addr(load_addr), .load_data(load_data), .load_done(load_done),
    .fetch_req(fetch_req), .fetch_pc(fetch_pc), .stall(stall),
    .instr(instr), .instr_valid(instr_valid), .instr_pc(instr_pc),
    .ready(ready), .fault(fault)
  );

  always #5 clk = ~clk;

  // Reference model: what the outputs must be, from the mode rules.
  logic [DATA_W-1:0] m_mem [DEPTH];
  int                m_mode = 0;          // 0 load, 1 run, 2 fault
  logic [DATA_W-1:0] e_instr = '0;
  logic              e_vld   = 1'b0;
  logic [PC_W-1:0]   e_pc    = '0;
  logic              e_fault = 1'b0;

  always @(posedge clk) begin
    int idx;
    if (rst) begin
      m_mode = 0; e_instr = 32'h0; e_vld = 1'b0; e_pc = '0; e_fault = 1'b0;
    end else if (m_mode == 0) begin
      if (load_we && int'(load_addr) < DEPTH) m_mem[int'(load_addr)] = load_data;
      e_vld = 1'b0;
      if (load_done) m_mode = 1;
    end else if (m_mode == 1) begin
      if (!stall) begin
        if (fetch_req) begin
          idx  = int'(fetch_pc) / 4;
          e_pc = fetch_pc;
          if (idx >= DEPTH || int'(fetch_pc) % 4 != 0) begin
            m_mode = 2; e_fault = 1'b1; e_instr = 32'h0; e_vld = 1'b0;
          end else begin
            e_instr = m_mem[idx]; e_vld = 1'b1;
          end
        end else begin
          e_vld = 1'b0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_instr", 64'(instr), 64'(e_instr));
      chk("m_valid", 64'(instr_valid), 64'(e_vld));
      chk("m_pc",    64'(instr_pc), 64'(e_pc));
      chk("m_ready", 64'(ready), 64'(m_mode == 1));
      chk("m_fault", 64'(fault), 64'(e_fault));
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic done);
    load_we = 1'b1; load_addr = a; load_data = d; load_done = done;
    tick();
    load_we = 1'b0; load_done = 1'b0;
  endtask

  task automatic fetch(input logic [PC_W-1:0] pc);
    fetch_req = 1'b1; fetch_pc = pc;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1; fetch_req = 1'b0; stall = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; load_we = 1'b0; load_addr = '0; load_data = '0; load_done = 1'b0;
    fetch_req = 1'b0; fetch_pc = '0; stall = 1'b0;
    tick();
    rst = 1'b0;
    chk_en = 1'b1;

    // T1: memory survives reset
    load(11'd0, 32'hDEADBEEF, 1'b0);
    do_reset();
    chk("rst_instr", 64'(instr), 64'h0);
    chk("rst_valid", 64'(instr_valid), 64'h0);
    chk("rst_ready", 64'(ready), 64'h0);
    chk("rst_fault", 64'(fault), 64'h0);
    load_done = 1'b1; tick(); load_done = 1'b0;
    chk("run_ready", 64'(ready), 64'h1);
    fetch(13'd0); fetch_req = 1'b0;
    chk("keep_mem0", 64'(instr), 64'hDEADBEEF);
    do_reset();

    // T2/T5: load program, guards in LOAD
    load(11'd0, 32'h20010007, 1'b0);
    load(11'd1, 32'h20020009, 1'b0);
    load(11'd2, 32'h00221820, 1'b0);
    load(11'd1024, 32'h12345678, 1'b0);
    chk("oor_load_fault", 64'(fault), 64'h0);
    fetch(13'd0); fetch_req = 1'b0;
    chk("load_fetch_vld", 64'(instr_valid), 64'h0);
    load(11'd3, 32'hAC030000, 1'b1);   // write together with load_done
    fetch(13'd0);
    chk("t2_w0", 64'(instr), 64'h20010007);
    chk("t2_pc0", 64'(instr_pc), 64'h0);
    fetch(13'd4);
    chk("t2_w1", 64'(instr), 64'h20020009);
    fetch(13'd8);
    chk("t2_w2", 64'(instr), 64'h00221820);
    fetch(13'd12);
    chk("t2_w3", 64'(instr), 64'hAC030000);
    chk("t2_pc3", 64'(instr_pc), 64'd12);
    chk("t2_vld3", 64'(instr_valid), 64'h1);
    fetch_req = 1'b0; tick();
    chk("idle_vld", 64'(instr_valid), 64'h0);
    chk("idle_hold", 64'(instr), 64'hAC030000);

    // T5: load_we in RUN ignored
    load(11'd0, 32'hFFFFFFFF, 1'b0);
    fetch(13'd0); fetch_req = 1'b0;
    chk("run_we_ignored", 64'(instr), 64'h20010007);

    // T3: stall
    fetch(13'd4);
    stall = 1'b1; fetch_pc = 13'd8;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_instr", 64'(instr), 64'h20020009);
      chk("stall_pc", 64'(instr_pc), 64'd4);
      chk("stall_vld", 64'(instr_valid), 64'h1);
    end
    stall = 1'b0; tick();
    chk("after_stall", 64'(instr), 64'h00221820);
    chk("after_stall_pc", 64'(instr_pc), 64'd8);

    // T4: faults
    stall = 1'b1; fetch(13'd6);
    chk("stall_no_fault", 64'(fault), 64'h0);
    stall = 1'b0; fetch(13'd6);
    chk("mis_fault", 64'(fault), 64'h1);
    chk("mis_instr", 64'(instr), 64'h0);
    chk("mis_pc", 64'(instr_pc), 64'd6);
    chk("mis_ready", 64'(ready), 64'h0);
    fetch(13'd0);
    chk("fault_hold_pc", 64'(instr_pc), 64'd6);
    do_reset();
    load_done = 1'b1; tick(); load_done = 1'b0;
    fetch(13'd4096);
    chk("range_fault", 64'(fault), 64'h1);
    chk("range_pc", 64'(instr_pc), 64'd4096);

    // Restart with retained program
    do_reset();
    load_done = 1'b1; tick(); load_done = 1'b0;
    fetch(13'd8); fetch_req = 1'b0;
    chk("restart_w2", 64'(instr), 64'h00221820);
    tick();

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
